// File: rtl/ps2_operation_decoder.sv
// ps2_operation_decoder
//   PS/2 keyboard front end for the game-logic core. Receives PS/2 frames,
//   tracks make/break/extended prefixes and emits single-cycle one-hot
//   command pulses on `operation`.
//     operation bit4 confirm/buy, bit3 left(a), bit2 up(w),
//               bit1 down(s), bit0 right(d)
//
// Ports
//   clk_100mhz  in   system clock
//   rst_n       in   asynchronous active-low reset
//   ps2_clk     in   raw PS/2 clock pin (asynchronous)
//   ps2_data    in   raw PS/2 data pin (asynchronous)
//   operation   out  [4:0] one-hot command, one cycle per accepted key press
//   scancode    out  [7:0] last valid received data byte
//   frame_err   out  one-cycle pulse on start/stop/parity error or timeout
//
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN
//   Defined   - a held-key bitmap suppresses auto-repeat make codes.
//   Undefined - every make code pulses; no held-key bitmap.
module ps2_operation_decoder #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] operation,
    output logic [7:0] scancode,
    output logic       frame_err
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers (bus idles high)
    // ------------------------------------------------------------------
    logic clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_data;
            dat_sync_q <= dat_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Clock glitch filter: the filtered level follows the synchronized
    // clock only after FILTER_LEN consecutive differing samples.
    // ------------------------------------------------------------------
    logic          filt_q, filt_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          fall_stb;

    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = '0;
        if (clk_sync_q != filt_q) begin
            if (flt_cnt_q == FLT_MAX) begin
                filt_d = clk_sync_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    assign fall_stb = filt_q & ~filt_d;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] wd_q, wd_d;
    logic          err_d;
    logic          frame_ok;
    logic          flag_clr;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        wd_d      = wd_q;
        err_d     = 1'b0;
        frame_ok  = 1'b0;
        flag_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (fall_stb) begin
                    if (!dat_sync_q) begin
                        state_d   = ST_RECV;
                        bit_cnt_d = 4'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (fall_stb) begin
                    wd_d = '0;
                    if (bit_cnt_q <= 4'd8) begin
                        shift_d   = {dat_sync_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (bit_cnt_q == 4'd9) begin
                        parity_d  = dat_sync_q;
                        bit_cnt_d = 4'd10;
                    end else begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                        if ((^shift_q ^ parity_q) && dat_sync_q) begin
                            frame_ok = 1'b1;
                        end else begin
                            err_d    = 1'b1;
                            flag_clr = 1'b1;
                        end
                    end
                end else if (wd_q == TMO_MAX) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    wd_d      = '0;
                    err_d     = 1'b1;
                    flag_clr  = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Byte decode
    // ------------------------------------------------------------------
    function automatic logic [4:0] key_map(input logic [7:0] code, input logic ext);
        logic [4:0] m;
        m = '0;
        if (!ext) begin
            case (code)
                8'h1C:        m = 5'b01000;
                8'h1D:        m = 5'b00100;
                8'h1B:        m = 5'b00010;
                8'h23:        m = 5'b00001;
                8'h5A, 8'h29: m = 5'b10000;
                default:      m = '0;
            endcase
        end else begin
            case (code)
                8'h6B:   m = 5'b01000;
                8'h75:   m = 5'b00100;
                8'h72:   m = 5'b00010;
                8'h74:   m = 5'b00001;
                default: m = '0;
            endcase
        end
        return m;
    endfunction

    logic [4:0] op_q, op_d;
    logic [7:0] scancode_q, scancode_d;
    logic       err_q;
    logic       brk_q, brk_d, ext_q, ext_d;
    logic [4:0] key;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [4:0] held_q, held_d;
`endif

    assign key = key_map(shift_q, ext_q);

    always_comb begin
        op_d       = '0;
        scancode_d = scancode_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
`ifdef PS2_TYPEMATIC_FILTER_EN
        held_d     = held_q;
`endif
        if (flag_clr) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end
        if (frame_ok) begin
            scancode_d = shift_q;
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                held_d = held_q & ~key;
`endif
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                // A repeat of an already-held key is swallowed.
                if ((key & held_q) == '0) begin
                    op_d = key;
                end
                held_d = held_q | key;
`else
                op_d = key;
`endif
                ext_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= 1'b1;
            flt_cnt_q  <= '0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            wd_q       <= '0;
            err_q      <= 1'b0;
            op_q       <= '0;
            scancode_q <= '0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held_q     <= '0;
`endif
        end else begin
            filt_q     <= filt_d;
            flt_cnt_q  <= flt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            wd_q       <= wd_d;
            err_q      <= err_d;
            op_q       <= op_d;
            scancode_q <= scancode_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held_q     <= held_d;
`endif
        end
    end

    assign operation = op_q;
    assign scancode  = scancode_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_operation_decoder.sv
module tb_ps2_operation_decoder;

    localparam int HALF = 25;
    localparam int TMO  = 2000;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam int EXP_REPEAT = 1;
`else
    localparam int EXP_REPEAT = 3;
`endif

    logic       clk_100mhz = 1'b0;
    logic       rst_n      = 1'b0;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic [4:0] operation;
    logic [7:0] scancode;
    logic       frame_err;

    ps2_operation_decoder #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .operation  (operation),
        .scancode   (scancode),
        .frame_err  (frame_err)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int vectors     = 0;
    int miscompares = 0;

    // Passive monitor: cumulative counts; tasks work with deltas.
    int         op_cycles  = 0;
    int         err_cycles = 0;
    int         multi_hot  = 0;
    logic [4:0] op_last    = '0;

    always @(negedge clk_100mhz) begin
        if (rst_n) begin
            if (operation != 5'b0) begin
                op_cycles = op_cycles + 1;
                op_last   = operation;
                if ($countones(operation) != 1) multi_hot = multi_hot + 1;
            end
            if (frame_err) err_cycles = err_cycles + 1;
        end
    end

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic flip);
        logic p;
        p = ~^b ^ flip;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk_100mhz);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            idle(HALF);
            ps2_clk = 1'b0;
            idle(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic flip);
        send_bits(make_frame(b, flip), 11);
        idle(40);
    endtask

    task automatic test_reset;
        idle(5);
        vectors++;
        if (operation !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_operation: got %b expected 00000", operation);
        end
        vectors++;
        if (scancode !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_scancode: got %h expected 00", scancode);
        end
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_frame_err: got %b expected 0", frame_err);
        end
        rst_n = 1'b1;
        idle(20);
    endtask

    task automatic test_reset_mid_frame;
        int ob, eb;
        send_bits(make_frame(8'h1B, 1'b0), 4);
        rst_n = 1'b0;
        idle(5);
        rst_n = 1'b1;
        idle(20);
        ob = op_cycles; eb = err_cycles;
        send_byte(8'h1B, 1'b0);
        vectors++;
        if (op_cycles - ob !== 1 || op_last !== 5'b00010) begin
            miscompares++;
            $display("FAIL midreset_s: got %0d pulses last %b expected 1 pulse 00010", op_cycles - ob, op_last);
        end
        vectors++;
        if (err_cycles - eb !== 0) begin
            miscompares++;
            $display("FAIL midreset_err: got %0d errors expected 0", err_cycles - eb);
        end
    endtask

    task automatic test_make_w;
        int ob, eb;
        ob = op_cycles; eb = err_cycles;
        send_byte(8'h1D, 1'b0);
        vectors++;
        if (op_cycles - ob !== 1 || op_last !== 5'b00100) begin
            miscompares++;
            $display("FAIL make_w: got %0d pulses last %b expected 1 pulse 00100", op_cycles - ob, op_last);
        end
        vectors++;
        if (scancode !== 8'h1D) begin
            miscompares++;
            $display("FAIL make_w_scancode: got %h expected 1d", scancode);
        end
        vectors++;
        if (err_cycles - eb !== 0) begin
            miscompares++;
            $display("FAIL make_w_err: got %0d errors expected 0", err_cycles - eb);
        end
    endtask

    task automatic test_break_w;
        int ob;
        ob = op_cycles;
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1D, 1'b0);
        vectors++;
        if (op_cycles - ob !== 0) begin
            miscompares++;
            $display("FAIL break_w: got %0d pulses expected 0", op_cycles - ob);
        end
        vectors++;
        if (scancode !== 8'h1D) begin
            miscompares++;
            $display("FAIL break_w_scancode: got %h expected 1d", scancode);
        end
    endtask

    task automatic test_extended;
        int ob;
        ob = op_cycles;
        send_byte(8'hE0, 1'b0);
        send_byte(8'h74, 1'b0);
        vectors++;
        if (op_cycles - ob !== 1 || op_last !== 5'b00001) begin
            miscompares++;
            $display("FAIL ext_right: got %0d pulses last %b expected 1 pulse 00001", op_cycles - ob, op_last);
        end
        ob = op_cycles;
        send_byte(8'h74, 1'b0);
        vectors++;
        if (op_cycles - ob !== 0) begin
            miscompares++;
            $display("FAIL plain_74: got %0d pulses expected 0", op_cycles - ob);
        end
        vectors++;
        if (scancode !== 8'h74) begin
            miscompares++;
            $display("FAIL plain_74_scancode: got %h expected 74", scancode);
        end
    endtask

    task automatic test_parity_err;
        int ob, eb;
        ob = op_cycles; eb = err_cycles;
        send_byte(8'h5A, 1'b1);
        vectors++;
        if (err_cycles - eb !== 1) begin
            miscompares++;
            $display("FAIL parity_err: got %0d errors expected 1", err_cycles - eb);
        end
        vectors++;
        if (op_cycles - ob !== 0) begin
            miscompares++;
            $display("FAIL parity_op: got %0d pulses expected 0", op_cycles - ob);
        end
        vectors++;
        if (scancode !== 8'h74) begin
            miscompares++;
            $display("FAIL parity_scancode: got %h expected 74", scancode);
        end
    endtask

    task automatic test_start_err;
        int eb;
        eb = err_cycles;
        ps2_data = 1'b1;
        idle(HALF);
        ps2_clk = 1'b0;
        idle(HALF);
        ps2_clk = 1'b1;
        idle(40);
        vectors++;
        if (err_cycles - eb !== 1) begin
            miscompares++;
            $display("FAIL start_err: got %0d errors expected 1", err_cycles - eb);
        end
    endtask

    task automatic test_timeout;
        int ob, eb;
        ob = op_cycles; eb = err_cycles;
        send_bits(make_frame(8'h5A, 1'b0), 5);
        idle(TMO + 300);
        vectors++;
        if (err_cycles - eb !== 1) begin
            miscompares++;
            $display("FAIL timeout_err: got %0d errors expected 1", err_cycles - eb);
        end
        vectors++;
        if (op_cycles - ob !== 0 || scancode !== 8'h74) begin
            miscompares++;
            $display("FAIL timeout_quiet: got %0d pulses scancode %h expected 0 pulses 74", op_cycles - ob, scancode);
        end
        ob = op_cycles; eb = err_cycles;
        send_byte(8'h1C, 1'b0);
        vectors++;
        if (op_cycles - ob !== 1 || op_last !== 5'b01000) begin
            miscompares++;
            $display("FAIL after_timeout_a: got %0d pulses last %b expected 1 pulse 01000", op_cycles - ob, op_last);
        end
        vectors++;
        if (err_cycles - eb !== 0) begin
            miscompares++;
            $display("FAIL after_timeout_err: got %0d errors expected 0", err_cycles - eb);
        end
    endtask

    task automatic test_typematic;
        int ob;
        ob = op_cycles;
        for (int i = 0; i < 3; i++) send_byte(8'h1D, 1'b0);
        vectors++;
        if (op_cycles - ob !== EXP_REPEAT) begin
            miscompares++;
            $display("FAIL typematic: got %0d pulses expected %0d", op_cycles - ob, EXP_REPEAT);
        end
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1D, 1'b0);
        ob = op_cycles;
        send_byte(8'h1D, 1'b0);
        vectors++;
        if (op_cycles - ob !== 1 || op_last !== 5'b00100) begin
            miscompares++;
            $display("FAIL repress_w: got %0d pulses last %b expected 1 pulse 00100", op_cycles - ob, op_last);
        end
    endtask

    task automatic test_one_hot;
        vectors++;
        if (multi_hot !== 0) begin
            miscompares++;
            $display("FAIL one_hot: got %0d multi-bit cycles expected 0", multi_hot);
        end
    endtask

    initial begin
        test_reset;
        test_reset_mid_frame;
        test_make_w;
        test_break_w;
        test_extended;
        test_parity_err;
        test_start_err;
        test_timeout;
        test_typematic;
        test_one_hot;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
